// File: rtl/chess_lab_pkg.sv
// Shared types and helpers for the chess lab board keypad: FSM encoding,
// per-frame scan result and small bit-vector helpers.
package chess_lab_pkg;

    localparam int BOARD_N        = 8;
    localparam int FILEIRA_OFFSET = 1;

    typedef enum logic [1:0] {
        ESPERA   = 2'd0,
        CONFIRMA = 2'd1,
        EMITE    = 2'd2,
        SOLTA    = 2'd3
    } estado_t;

    typedef enum logic [1:0] {
        NENHUM   = 2'd0,
        UNICO    = 2'd1,
        MULTIPLO = 2'd2
    } resultado_t;

    // Number of set bits, saturated at 2 (we only care about 0 / 1 / many).
    function automatic logic [1:0] conta_sat(input logic [BOARD_N-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < BOARD_N; i++) n += int'(v[i]);
        return (n >= 2) ? 2'd2 : 2'(n);
    endfunction

    // Index of the lowest set bit (0 when none is set).
    function automatic logic [2:0] primeira(input logic [BOARD_N-1:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = BOARD_N - 1; i >= 0; i--) if (v[i]) idx = 3'(i);
        return idx;
    endfunction

endpackage

// File: rtl/varredura_matriz.sv
// Row scanner for the 8x8 board matrix: column synchronizer, one-hot row
// rotation with a settle window per row, and a per-frame accumulator that
// reports NENHUM / UNICO(r,c) / MULTIPLO once per frame.
module varredura_matriz
    import chess_lab_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [7:0]       colunas,
    output logic [7:0]       linhas,
    output logic             frame_valid,
    output resultado_t       resultado,
    output logic [2:0]       fileira,
    output logic [2:0]       coluna
);

    localparam int                SW   = $clog2(SETTLE_CYCLES);
    localparam logic [SW-1:0]     LAST = SW'(SETTLE_CYCLES - 1);

    logic [7:0]    sync1_q, sync2_q;
    logic [SW-1:0] settle_q;
    logic [2:0]    row_q;
    logic [1:0]    acc_cnt_q;
    logic [2:0]    acc_r_q, acc_c_q;
    logic          fv_q;
    resultado_t    res_q;
    logic [2:0]    res_r_q, res_c_q;

    logic          amostra;
    logic [1:0]    pop;
    logic [2:0]    soma;
    logic [1:0]    cnt_novo;
    logic          primeira_tecla;
    logic [2:0]    r_novo, c_novo;

    // Merge the row being sampled into the running frame accumulators.
    always_comb begin
        amostra        = (settle_q == LAST);
        pop            = conta_sat(sync2_q);
        soma           = {1'b0, acc_cnt_q} + {1'b0, pop};
        cnt_novo       = (soma >= 3'd2) ? 2'd2 : soma[1:0];
        primeira_tecla = (acc_cnt_q == 2'd0) && (pop != 2'd0);
        r_novo         = primeira_tecla ? row_q : acc_r_q;
        c_novo         = primeira_tecla ? primeira(sync2_q) : acc_c_q;
    end

    // Two-flop synchronizer on the asynchronous column lines.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= colunas;
            sync2_q <= sync1_q;
        end
    end

    // Settle counter and row rotator; the row advances right after sampling.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            settle_q <= '0;
            row_q    <= '0;
        end else if (amostra) begin
            settle_q <= '0;
            row_q    <= row_q + 3'd1;
        end else begin
            settle_q <= settle_q + SW'(1);
        end
    end

    // Frame accumulator; publishes the result after row 7 and clears itself.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_cnt_q <= '0;
            acc_r_q   <= '0;
            acc_c_q   <= '0;
            fv_q      <= 1'b0;
            res_q     <= NENHUM;
            res_r_q   <= '0;
            res_c_q   <= '0;
        end else begin
            fv_q <= 1'b0;
            if (amostra) begin
                if (row_q == 3'd7) begin
                    fv_q      <= 1'b1;
                    res_q     <= (cnt_novo == 2'd0) ? NENHUM :
                                 (cnt_novo == 2'd1) ? UNICO : MULTIPLO;
                    res_r_q   <= r_novo;
                    res_c_q   <= c_novo;
                    acc_cnt_q <= '0;
                    acc_r_q   <= '0;
                    acc_c_q   <= '0;
                end else begin
                    acc_cnt_q <= cnt_novo;
                    acc_r_q   <= r_novo;
                    acc_c_q   <= c_novo;
                end
            end
        end
    end

    assign linhas      = 8'd1 << row_q;
    assign frame_valid = fv_q;
    assign resultado   = res_q;
    assign fileira     = res_r_q;
    assign coluna      = res_c_q;

endmodule

// File: rtl/teclado_tabuleiro.sv
// Move-entry transmitter: scans the board matrix, debounces a single press
// over whole frames and emits one temJogada strobe per accepted square.
// Optional TECLADO_DEBUG_EN adds db_estado / db_varredura for hexa7seg.
module teclado_tabuleiro
    import chess_lab_pkg::*;
#(
    parameter int SETTLE_CYCLES   = 4,
    parameter int DEBOUNCE_FRAMES = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       habilita,
    input  logic [7:0] colunas,
    output logic [7:0] linhas,
    output logic [3:0] jogadaFileira,
    output logic [3:0] jogadaColuna,
    output logic       temJogada,
    output logic       multiplo
`ifdef TECLADO_DEBUG_EN
    ,
    output logic [3:0] db_estado,
    output logic [2:0] db_varredura
`endif
);

    localparam logic [3:0] DB = 4'(DEBOUNCE_FRAMES);

    logic       fv;
    resultado_t res;
    logic [2:0] res_r, res_c;

    estado_t    estado_q;
    logic [3:0] cnt_q;
    logic [2:0] cand_r_q, cand_c_q;
    logic [3:0] fileira_q, coluna_q;
    logic       tem_q, mult_q;
    logic       mesma;

    varredura_matriz #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_varredura (
        .clock       (clock),
        .reset       (reset),
        .colunas     (colunas),
        .linhas      (linhas),
        .frame_valid (fv),
        .resultado   (res),
        .fileira     (res_r),
        .coluna      (res_c)
    );

    assign mesma = (res_r == cand_r_q) && (res_c == cand_c_q);

    // Debounce FSM with registered outputs; habilita=0 overrides the next state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q  <= ESPERA;
            cnt_q     <= '0;
            cand_r_q  <= '0;
            cand_c_q  <= '0;
            fileira_q <= '0;
            coluna_q  <= '0;
            tem_q     <= 1'b0;
            mult_q    <= 1'b0;
        end else begin
            tem_q <= 1'b0;
            if (fv) mult_q <= (res == MULTIPLO);
            case (estado_q)
                ESPERA: if (fv && res == UNICO) begin
                    cand_r_q <= res_r;
                    cand_c_q <= res_c;
                    cnt_q    <= 4'd1;
                    estado_q <= (DEBOUNCE_FRAMES == 1) ? EMITE : CONFIRMA;
                end
                CONFIRMA: if (fv) begin
                    if (res == UNICO && mesma) begin
                        cnt_q <= cnt_q + 4'd1;
                        if (cnt_q + 4'd1 >= DB) estado_q <= EMITE;
                    end else if (res == UNICO) begin
                        cand_r_q <= res_r;
                        cand_c_q <= res_c;
                        cnt_q    <= 4'd1;
                    end else begin
                        estado_q <= ESPERA;
                        cnt_q    <= '0;
                    end
                end
                EMITE: begin
                    fileira_q <= {1'b0, cand_r_q} + 4'(FILEIRA_OFFSET);
                    coluna_q  <= {1'b0, cand_c_q};
                    tem_q     <= 1'b1;
                    cnt_q     <= '0;
                    estado_q  <= SOLTA;
                end
                SOLTA: if (fv) begin
                    // Any press restarts the release count, so a held key never re-emits.
                    if (res == NENHUM) begin
                        if (cnt_q + 4'd1 >= DB) begin
                            estado_q <= ESPERA;
                            cnt_q    <= '0;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end else begin
                        cnt_q <= '0;
                    end
                end
                default: estado_q <= ESPERA;
            endcase
            if (!habilita) begin
                estado_q <= ESPERA;
                cnt_q    <= '0;
            end
        end
    end

    assign jogadaFileira = fileira_q;
    assign jogadaColuna  = coluna_q;
    assign temJogada     = tem_q;
    assign multiplo      = mult_q;

`ifdef TECLADO_DEBUG_EN
    assign db_estado    = {2'b00, estado_q};
    assign db_varredura = primeira(linhas);
`endif

endmodule

// File: tb/tb_teclado_tabuleiro.sv
// Directed bench for teclado_tabuleiro (SETTLE_CYCLES=4, DEBOUNCE_FRAMES=3).
module tb_teclado_tabuleiro;

    logic            clock = 1'b0;
    logic            reset;
    logic            habilita;
    logic [7:0]      colunas;
    logic [7:0]      linhas;
    logic [3:0]      jogadaFileira, jogadaColuna;
    logic            temJogada, multiplo;
    logic [7:0][7:0] keys;

    int n_chk  = 0;
    int n_pass = 0;
    int n_pulse = 0;
    logic [3:0] p_fil = '0, p_col = '0;

    always #5 clock = ~clock;

    teclado_tabuleiro #(.SETTLE_CYCLES(4), .DEBOUNCE_FRAMES(3)) dut (
        .clock         (clock),
        .reset         (reset),
        .habilita      (habilita),
        .colunas       (colunas),
        .linhas        (linhas),
        .jogadaFileira (jogadaFileira),
        .jogadaColuna  (jogadaColuna),
        .temJogada     (temJogada),
        .multiplo      (multiplo)
    );

    // Board model: a pressed key connects its row drive to its column line.
    always_comb begin
        colunas = '0;
        for (int r = 0; r < 8; r++) if (linhas[r]) colunas = colunas | keys[r];
    end

    // Count strobes and capture the square presented in the strobe cycle.
    always @(posedge clock) begin
        if (reset && temJogada) begin
            n_pulse <= n_pulse + 1;
            p_fil   <= jogadaFileira;
            p_col   <= jogadaColuna;
        end
    end

    typedef struct {
        logic [63:0] keys;
        logic        hab;
        int          frames;
        int          pulses;
        logic [3:0]  fil;
        logic [3:0]  col;
        logic        mult;
    } vec_t;

    vec_t vt[25];

    function automatic logic [63:0] k(input int r, input int c);
        return 64'd1 << (r * 8 + c);
    endfunction

    function automatic vec_t mk(input logic [63:0] ks, input logic h, input int fr,
                                input int p, input int f, input int c, input logic m);
        vec_t v;
        v.keys = ks; v.hab = h; v.frames = fr; v.pulses = p;
        v.fil = 4'(f); v.col = 4'(c); v.mult = m;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    // Stop at the negedge of the first clock of a frame (linhas just wrapped to row 0).
    task automatic to_frame_start();
        logic [7:0] prev;
        prev = linhas;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (linhas == 8'h01 && prev == 8'h80) return;
            prev = linhas;
        end
        n_chk++;
        $display("FAIL frame_sync: no row wrap seen within 40 clocks");
    endtask

    task automatic avalia(input int i, input int pulsos);
        string s;
        s = $sformatf("vec%0d", i);
        chk({s, "_pulses"}, 32'(pulsos), 32'(vt[i].pulses));
        if (vt[i].pulses > 0) begin
            chk({s, "_strobe_fil"}, 32'(p_fil), 32'(vt[i].fil));
            chk({s, "_strobe_col"}, 32'(p_col), 32'(vt[i].col));
        end
        chk({s, "_fileira"}, 32'(jogadaFileira), 32'(vt[i].fil));
        chk({s, "_coluna"}, 32'(jogadaColuna), 32'(vt[i].col));
        chk({s, "_multiplo"}, 32'(multiplo), 32'(vt[i].mult));
    endtask

    initial begin
        int base;
        // keys, habilita, frames held, strobes expected, fileira, coluna, multiplo
        vt[0]  = mk(64'd0,             1'b1, 10, 0, 0, 0, 1'b0);
        vt[1]  = mk(k(2,4),            1'b1, 6,  1, 3, 4, 1'b0);
        vt[2]  = mk(64'd0,             1'b1, 3,  0, 3, 4, 1'b0);
        vt[3]  = mk(k(0,0),            1'b1, 1,  0, 3, 4, 1'b0);
        vt[4]  = mk(64'd0,             1'b1, 1,  0, 3, 4, 1'b0);
        vt[5]  = mk(k(0,0),            1'b1, 1,  0, 3, 4, 1'b0);
        vt[6]  = mk(64'd0,             1'b1, 1,  0, 3, 4, 1'b0);
        vt[7]  = mk(k(0,0),            1'b1, 1,  0, 3, 4, 1'b0);
        vt[8]  = mk(64'd0,             1'b1, 1,  0, 3, 4, 1'b0);
        vt[9]  = mk(k(0,0),            1'b1, 4,  1, 1, 0, 1'b0);
        vt[10] = mk(64'd0,             1'b1, 3,  0, 1, 0, 1'b0);
        vt[11] = mk(k(1,1) | k(5,6),   1'b1, 2,  0, 1, 0, 1'b1);
        vt[12] = mk(k(1,1),            1'b1, 3,  1, 2, 1, 1'b0);
        vt[13] = mk(64'd0,             1'b1, 3,  0, 2, 1, 1'b0);
        vt[14] = mk(k(3,3),            1'b1, 2,  0, 2, 1, 1'b0);
        vt[15] = mk(k(4,5),            1'b1, 3,  1, 5, 5, 1'b0);
        vt[16] = mk(64'd0,             1'b1, 3,  0, 5, 5, 1'b0);
        vt[17] = mk(k(6,2),            1'b1, 2,  0, 5, 5, 1'b0);
        vt[18] = mk(k(6,2) | k(6,0),   1'b1, 1,  0, 5, 5, 1'b1);
        vt[19] = mk(k(6,2),            1'b1, 2,  0, 5, 5, 1'b0);
        vt[20] = mk(64'd0,             1'b1, 3,  0, 5, 5, 1'b0);
        vt[21] = mk(k(7,7),            1'b1, 2,  0, 5, 5, 1'b0);
        vt[22] = mk(k(7,7),            1'b0, 2,  0, 5, 5, 1'b0);
        vt[23] = mk(k(7,7),            1'b1, 3,  1, 8, 7, 1'b0);
        vt[24] = mk(64'd0,             1'b1, 3,  0, 8, 7, 1'b0);

        reset    = 1'b0;
        habilita = 1'b1;
        keys     = '0;
        #1;
        chk("rst_linhas",  32'(linhas), 32'h01);
        chk("rst_fileira", 32'(jogadaFileira), 32'h0);
        chk("rst_coluna",  32'(jogadaColuna), 32'h0);
        chk("rst_tem",     32'(temJogada), 32'h0);
        chk("rst_mult",    32'(multiplo), 32'h0);
        repeat (3) @(negedge clock);
        reset = 1'b1;

        // Row drive rotates every 4 clocks and wraps 0x80 -> 0x01.
        for (int j = 0; j < 36; j++) begin
            if (j > 0) @(negedge clock);
            chk($sformatf("scan_j%0d", j), 32'(linhas), 32'(8'd1 << ((j / 4) % 8)));
        end

        to_frame_start();
        base = n_pulse;
        for (int i = 0; i < 25; i++) begin
            keys     = vt[i].keys;
            habilita = vt[i].hab;
            repeat (4) @(negedge clock);
            if (i > 0) begin
                avalia(i - 1, n_pulse - base);
                base = n_pulse;
            end
            repeat (vt[i].frames * 32 - 4) @(negedge clock);
        end
        repeat (4) @(negedge clock);
        avalia(24, n_pulse - base);

        // Reset in the middle of a confirmation discards the progress.
        to_frame_start();
        keys = k(2,2);
        repeat (2 * 32 + 4) @(negedge clock);
        base = n_pulse;
        reset = 1'b0;
        #1;
        chk("midrst_linhas",  32'(linhas), 32'h01);
        chk("midrst_fileira", 32'(jogadaFileira), 32'h0);
        chk("midrst_coluna",  32'(jogadaColuna), 32'h0);
        chk("midrst_tem",     32'(temJogada), 32'h0);
        chk("midrst_mult",    32'(multiplo), 32'h0);
        chk("midrst_no_pulse_before", 32'(n_pulse - base), 32'd0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        base = n_pulse;
        repeat (68) @(negedge clock);
        chk("midrst_no_pulse_2fr", 32'(n_pulse - base), 32'd0);
        repeat (32) @(negedge clock);
        chk("midrst_pulse_3fr", 32'(n_pulse - base), 32'd1);
        chk("midrst_fileira_after", 32'(jogadaFileira), 32'd3);
        chk("midrst_coluna_after",  32'(jogadaColuna), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/teclado_tabuleiro.md
Name: teclado_tabuleiro

Overview:
Move-entry transmitter for the chess lab game: scans an 8x8 reed-switch/button matrix under the board and produces the `jogadaFileira` / `jogadaColuna` / `temJogada` interface the game core consumes. It drives rows one-hot and samples columns through a synchronizer. A press is debounced over whole scan frames, and each confirmed press yields exactly one single-cycle `temJogada` strobe with a stable square. It sits between the board pins and the game top level.

Parameters:
SETTLE_CYCLES, 4, clocks each row is driven before its columns are sampled; must be >=3 to cover the synchronizer.
DEBOUNCE_FRAMES, 3, consecutive identical frames needed to accept a press or a release; range 1..15.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
habilita  in  1  1 = emission allowed; 0 = forces the FSM to ESPERA, scanning continues
colunas  in  8  raw column sense lines, active-high, asynchronous
linhas  out  8  one-hot row drive, active-high
jogadaFileira  out  4  rank of the accepted square, 1..8 (row index+1)
jogadaColuna  out  4  file of the accepted square, 0..7 (0=A)
temJogada  out  1  one-cycle strobe; square valid in the same cycle and held afterwards
multiplo  out  1  1 while the last completed frame contained more than one pressed key

Behaviour:
- Reset values (async, `reset`=0): linhas=8'b00000001, jogadaFileira=0, jogadaColuna=0, temJogada=0, multiplo=0, state ESPERA, all counters 0.
- Scan:
  - `colunas` passes through a 2-FF synchronizer.
  - Each row r (0..7) is driven for SETTLE_CYCLES clocks. The synchronized columns are sampled on the last clock of that row window, then linhas rotates left, wrapping 7->0.
  - One frame is 8*SETTLE_CYCLES clocks.
  - Per-frame accumulation:
    - key count saturates at 2;
    - first pressed (r,c) is captured, with lowest row and then lowest column winning.
  - The frame result (NENHUM / UNICO(r,c) / MULTIPLO) is valid for one clock right after row 7 is sampled. The accumulators clear on the same clock.
- `multiplo` updates once per frame from that frame's result.
- FSM, advancing only on frame-result clocks except EMITE:
  - ESPERA:
    - UNICO -> latch candidate, cnt=1; go to CONFIRMA, or to EMITE if DEBOUNCE_FRAMES=1.
    - Otherwise stay.
  - CONFIRMA:
    - UNICO with the same square -> cnt+1; on reaching DEBOUNCE_FRAMES go to EMITE.
    - UNICO with a different square -> reload candidate, cnt=1, stay.
    - NENHUM or MULTIPLO -> ESPERA, cnt=0.
  - EMITE, exactly one clock:
    - load jogadaFileira = r+1 and jogadaColuna = c;
    - temJogada=1;
    - go to SOLTA.
  - SOLTA:
    - NENHUM -> cnt+1; on reaching DEBOUNCE_FRAMES go to ESPERA.
    - Any press -> cnt=0, stay. A held key never re-emits.
- `habilita`=0 in any state forces ESPERA on the next clock and clears cnt. If EMITE is active in that same clock, the strobe is still issued. jogada outputs keep their last value.
- Latency from a clean press stable from frame start to temJogada: at most (DEBOUNCE_FRAMES+1) frames + 3 clocks.
- Reset mid-frame discards the partial frame; scanning restarts at row 0.
- cnt is 4 bits and cannot exceed DEBOUNCE_FRAMES.

Optional Feature:
TECLADO_DEBUG_EN
- Defined: adds output port db_estado[3:0] with encoding ESPERA=0, CONFIRMA=1, EMITE=2, SOLTA=3, and db_varredura[2:0] carrying the current row index. Both are intended for hexa7seg.
- Undefined: these ports and their logic do not exist. Functional behaviour is identical.

Decomposition:
- Shared package chess_lab_pkg: FSM state typedef/encoding, BOARD_N=8, frame-result enum (NENHUM/UNICO/MULTIPLO), FILEIRA_OFFSET=1.
- One sub-module, varredura_matriz, contains:
  - synchronizer;
  - row rotator and settle counter;
  - per-frame accumulator, outputting frame_valid, result and (r,c).
- The debounce FSM and output registers live in teclado_tabuleiro.

Test Plan:
(SETTLE_CYCLES=4, DEBOUNCE_FRAMES=3, frame=32 clocks)
- Reset deasserted, no keys, habilita=1 -> linhas cycles 01,02,..,80,01 every 4 clocks; temJogada never asserts over 10 frames.
- Key row 2/col 4 held 6 frames -> exactly one temJogada pulse within 4 frames + 3 clocks, with jogadaFileira=3 and jogadaColuna=4; no second pulse while held.
- Key row 0/col 0 bouncing (pressed 1 frame, released 1 frame, repeated) -> no strobe. Then held 4 frames -> one strobe with fileira=1, coluna=0.
- Keys (1,1) and (5,6) held together -> multiplo=1 after the first frame, no strobe. Releasing (5,6) -> strobe with fileira=2, coluna=1.
- habilita=0 during CONFIRMA on key (7,7) -> no strobe. habilita back to 1 with the key still held -> strobe with fileira=8, coluna=7 after 3 further frames.
- reset pulsed low mid-CONFIRMA -> all outputs 0 and linhas=01 asynchronously; no strobe until a fresh 3-frame confirmation.
